// File: rtl/reg_cfg_pkg.sv
// -----------------------------------------------------------------------------
// reg_cfg_pkg
// Shared types and constants for the host-side register configuration writer.
//   state_t            : frame parser state (IDLE, ADDR, DATA, CSUM, WRITE)
//   *_IDX              : register map indices driven on addr_out
//   HDR_BYTE_DEFAULT   : default frame start marker
//   frame_csum()       : 8-bit modular sum of header, address and data bytes
// -----------------------------------------------------------------------------
package reg_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    WRITE
  } state_t;

  localparam logic [2:0] ACC_IDX    = 3'd0;
  localparam logic [2:0] GYRO_IDX   = 3'd1;
  localparam logic [2:0] MAG_IDX    = 3'd2;
  localparam logic [2:0] DEC_IDX    = 3'd3;
  localparam logic [2:0] NOLOAD_IDX = 3'd7;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Carries beyond bit 7 are discarded, giving the mod-256 frame checksum.
  function automatic logic [7:0] frame_csum(input logic [7:0] hdr,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return hdr + addr + data;
  endfunction

endpackage

// File: rtl/reg_cfg_writer_if.sv
// -----------------------------------------------------------------------------
// reg_cfg_writer_if
// Byte-wide valid/ready link from the host byte receiver.
//   rx_data  : incoming host byte
//   rx_valid : rx_data valid
//   rx_ready : byte taken on a posedge where rx_valid & rx_ready
// Modports: master = host byte receiver, slave = reg_cfg_writer.
// -----------------------------------------------------------------------------
interface reg_cfg_writer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/reg_cfg_timeout.sv
// -----------------------------------------------------------------------------
// reg_cfg_timeout
// Inter-byte timeout counter for the frame parser.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the count (byte accepted or parser idle); wins over en
//   en       : count this cycle (inside a frame, no byte accepted)
//   expire   : count has reached TIMEOUT_CYCLES-1 while still enabled
// -----------------------------------------------------------------------------
module reg_cfg_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned  CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Gated by en, so a byte accepted on the expiring edge suppresses the abort.
  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/reg_cfg_writer.sv
// -----------------------------------------------------------------------------
// reg_cfg_writer
// Parses HDR, ADDR, DATA, CSUM frames from the host byte link and issues one
// single-cycle write to the sensor register map per valid frame.
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : host byte link (reg_cfg_writer_if.slave)
//   addr_out   : register map addr_in; NOLOAD_IDX (3'b111) except in WRITE
//   data_out   : register map data_in; holds the last written value
//   busy       : frame in progress
//   frame_ok   : one-cycle pulse, write issued
//   frame_err  : one-cycle pulse, frame discarded (bad frame or timeout)
//   err_cnt    : saturating frame_err count (only with REG_CFG_ERR_CNT_EN)
// Optional feature macro: REG_CFG_ERR_CNT_EN
// -----------------------------------------------------------------------------
module reg_cfg_writer
  import reg_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
  parameter int unsigned NUM_REGS       = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg_cfg_writer_if.slave rx,
  output logic [2:0]      addr_out,
  output logic [7:0]      data_out,
  output logic            busy,
  output logic            frame_ok,
`ifdef REG_CFG_ERR_CNT_EN
  output logic            frame_err,
  output logic [7:0]      err_cnt
`else
  output logic            frame_err
`endif
);

  state_t     state_q, state_d;
  logic [7:0] addr_q, data_q;
  logic       accept, frame_valid, in_frame, expire, err_set;

  assign accept   = rx.rx_valid && rx.rx_ready;
  assign in_frame = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);

  // Checked against the incoming CSUM byte, so only meaningful in CSUM.
  assign frame_valid = (rx.rx_data == frame_csum(HDR_BYTE, addr_q, data_q)) &&
                       (addr_q[7:3] == 5'd0) &&
                       (addr_q < 8'(NUM_REGS));

  assign err_set = ((state_q == CSUM) && accept && !frame_valid) || expire;

  reg_cfg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_frame || accept),
    .en     (in_frame && !accept),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && (rx.rx_data == HDR_BYTE)) state_d = ADDR;
      ADDR:  if (accept) state_d = DATA; else if (expire) state_d = IDLE;
      DATA:  if (accept) state_d = CSUM; else if (expire) state_d = IDLE;
      CSUM:  if (accept) state_d = frame_valid ? WRITE : IDLE;
             else if (expire) state_d = IDLE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rx.rx_ready = 1'b1;
    busy        = 1'b1;
    frame_ok    = 1'b0;
    addr_out    = NOLOAD_IDX;
    unique case (state_q)
      IDLE:  busy = 1'b0;
      WRITE: begin
        rx.rx_ready = 1'b0;
        frame_ok    = 1'b1;
        addr_out    = addr_q[2:0];
      end
      default: ;
    endcase
  end

  // Frame fields, write data and the registered error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      data_out  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      if ((state_q == ADDR) && accept) addr_q <= rx.rx_data;
      if ((state_q == DATA) && accept) data_q <= rx.rx_data;
      // data_out only changes when a write is actually issued.
      if ((state_q == CSUM) && accept && frame_valid) data_out <= data_q;
      frame_err <= err_set;
    end
  end

`ifdef REG_CFG_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_cnt <= 8'd0;
    else if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_reg_cfg_writer.sv
// -----------------------------------------------------------------------------
// tb_reg_cfg_writer
// Self-checking bench for reg_cfg_writer: reset state, a vector table of
// whole frames, hand-written back-to-back / timeout / reset sequences and
// randomized frame traffic against a frame-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_cfg_writer;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] addr_out;
  logic [7:0] data_out;
  logic       busy, frame_ok, frame_err;
`ifdef REG_CFG_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  reg_cfg_writer_if bus ();

  reg_cfg_writer #(
    .TIMEOUT_CYCLES (TO),
    .HDR_BYTE       (8'hA5),
    .NUM_REGS       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (bus),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .busy      (busy),
    .frame_ok  (frame_ok),
`ifdef REG_CFG_ERR_CNT_EN
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
`else
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observation side: register map model plus write / error logs.
  logic [7:0]  map [4] = '{default: 8'h00};
  logic [10:0] act_q [$];
  int          ok_cyc [$];
  int          cyc = 0, n_ok = 0, n_err = 0, n_spur = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok) begin
        act_q.push_back({addr_out, data_out});
        ok_cyc.push_back(cyc);
        n_ok++;
      end
      if (frame_err) n_err++;
      if (addr_out != 3'b111 && !frame_ok) n_spur++;
      // Register map loads addr_in/data_in at the following posedge.
      if (addr_out < 3'd4) map[addr_out] = data_out;
    end
  end

  // Drive one byte and return right after the posedge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready wait: got stuck low, expected high within 50 cycles");
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] c);
    send_byte(h); send_byte(a); send_byte(d); send_byte(c);
  endtask

  function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] d);
    return 8'(8'hA5 + a + d);
  endfunction

  typedef struct {
    logic [7:0] b [4];
    logic       exp_ok;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ok0, err0;
    logic [31:0] snap;
    logic [7:0]  exp_regs [4];
    logic [10:0] exp_q [$];
    int          exp_err;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    vecs[0] = '{b: '{8'hA5, 8'h00, 8'hAA, 8'h4F}, exp_ok: 1'b1, exp_addr: 3'd0, exp_data: 8'hAA};
    vecs[1] = '{b: '{8'hA5, 8'h01, 8'hA2, 8'h48}, exp_ok: 1'b1, exp_addr: 3'd1, exp_data: 8'hA2};
    vecs[2] = '{b: '{8'hA5, 8'h03, 8'h2A, 8'hD2}, exp_ok: 1'b1, exp_addr: 3'd3, exp_data: 8'h2A};
    vecs[3] = '{b: '{8'hA5, 8'h02, 8'hBA, 8'h00}, exp_ok: 1'b0, exp_addr: 3'd7, exp_data: 8'h00};
    vecs[4] = '{b: '{8'hA5, 8'h05, 8'h11, 8'hBB}, exp_ok: 1'b0, exp_addr: 3'd7, exp_data: 8'h00};
    vecs[5] = '{b: '{8'hA5, 8'h08, 8'h10, 8'hBD}, exp_ok: 1'b0, exp_addr: 3'd7, exp_data: 8'h00};
    vecs[6] = '{b: '{8'hA5, 8'h04, 8'h00, 8'hA9}, exp_ok: 1'b0, exp_addr: 3'd7, exp_data: 8'h00};
    vecs[7] = '{b: '{8'hA5, 8'h03, 8'hFF, 8'hA7}, exp_ok: 1'b1, exp_addr: 3'd3, exp_data: 8'hFF};

    // Reset state
    #12;
    check("rst addr_out", 32'(addr_out), 32'h7);
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst frame_ok", 32'(frame_ok), 32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    check("rst rx_ready", 32'(bus.rx_ready), 32'h1);
`ifdef REG_CFG_ERR_CNT_EN
    check("rst err_cnt", 32'(err_cnt), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      ok0  = n_ok;
      err0 = n_err;
      snap = {map[3], map[2], map[1], map[0]};
      send_frame(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3]);
      idle(3);
      check($sformatf("vec%0d ok", i), 32'(n_ok - ok0), 32'(vecs[i].exp_ok));
      check($sformatf("vec%0d err", i), 32'(n_err - err0), 32'(!vecs[i].exp_ok));
      if (vecs[i].exp_ok) begin
        check($sformatf("vec%0d write", i), 32'(act_q[$]), {21'd0, vecs[i].exp_addr, vecs[i].exp_data});
        check($sformatf("vec%0d map", i), 32'(map[vecs[i].exp_addr]), 32'(vecs[i].exp_data));
      end else begin
        check($sformatf("vec%0d map unchanged", i), {map[3], map[2], map[1], map[0]}, snap);
      end
    end

    // Garbage before a header is dropped without error
    ok0 = n_ok; err0 = n_err;
    send_byte(8'h3C); send_byte(8'h7E);
    send_frame(8'hA5, 8'h01, 8'h55, csum(8'h01, 8'h55));
    idle(3);
    check("garbage err", 32'(n_err - err0), 32'd0);
    check("garbage ok", 32'(n_ok - ok0), 32'd1);
    check("garbage map", 32'(map[1]), 32'h55);

    // Back-to-back frames with rx_valid held high
    ok0 = n_ok;
    send_frame(8'hA5, 8'h01, 8'hA2, 8'h48);
    send_frame(8'hA5, 8'h03, 8'h2A, 8'hD2);
    idle(3);
    check("b2b ok count", 32'(n_ok - ok0), 32'd2);
    check("b2b gap", 32'(ok_cyc[$] - ok_cyc[$-1]), 32'd5);
    check("b2b gyro", 32'(map[1]), 32'hA2);
    check("b2b dec", 32'(map[3]), 32'h2A);
    check("b2b data_out hold", 32'(data_out), 32'h2A);

    // Timeout in DATA, then recovery
    begin
      int k = 1;
      ok0 = n_ok; err0 = n_err;
      send_byte(8'hA5); send_byte(8'h00);
      idle(1);
      while (!frame_err && k < int'(TO) + 10) begin
        @(negedge clk);
        k++;
      end
      check("timeout seen", 32'(frame_err), 32'd1);
      check("timeout latency", 32'(k >= int'(TO) - 1 && k <= int'(TO) + 1), 32'd1);
      idle(2);
      check("timeout busy", 32'(busy), 32'd0);
      check("timeout no write", 32'(n_ok - ok0), 32'd0);
      send_frame(8'hA5, 8'h02, 8'h33, csum(8'h02, 8'h33));
      idle(3);
      check("after timeout ok", 32'(n_ok - ok0), 32'd1);
      check("after timeout mag", 32'(map[2]), 32'h33);
    end

    // Reset during DATA
    ok0 = n_ok; err0 = n_err;
    send_byte(8'hA5); send_byte(8'h01);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst addr_out", 32'(addr_out), 32'h7);
    check("midrst frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'hA2); send_byte(8'h48);
    idle(TO + 4);
    check("midrst ok", 32'(n_ok - ok0), 32'd0);
    check("midrst err", 32'(n_err - err0), 32'd0);

    // Randomized frames against a frame-level model
    act_q.delete();
    for (int r = 0; r < 4; r++) exp_regs[r] = map[r];
    err0 = n_err;
    exp_err = 0;
    for (int f = 0; f < 200; f++) begin
      logic [7:0] a, d, c, g;
      logic       good;
      int         ng;
      ng = $urandom_range(0, 2);
      for (int j = 0; j < ng; j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) < 8);
      c = good ? csum(a, d) : 8'(csum(a, d) + 8'($urandom_range(1, 255)));
      send_byte(8'hA5); idle($urandom_range(0, 3));
      send_byte(a);     idle($urandom_range(0, 3));
      send_byte(d);     idle($urandom_range(0, 3));
      send_byte(c);
      if (good && a < 8'd4) begin
        exp_q.push_back({a[2:0], d});
        exp_regs[a[1:0]] = d;
      end else begin
        exp_err++;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    check("rand write count", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      if (act_q[i] !== exp_q[i]) check($sformatf("rand write %0d", i), 32'(act_q[i]), 32'(exp_q[i]));
    check("rand err count", 32'(n_err - err0), 32'(exp_err));
    for (int r = 0; r < 4; r++) check($sformatf("rand reg%0d", r), 32'(map[r]), 32'(exp_regs[r]));
    check("no spurious loads", 32'(n_spur), 32'd0);

`ifdef REG_CFG_ERR_CNT_EN
    // Saturating error counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send_frame(8'hA5, 8'h02, 8'hBA, 8'h00);
      if (i == 9) begin
        idle(2);
        check("err_cnt 10", 32'(err_cnt), 32'd10);
      end
    end
    idle(3);
    check("err_cnt sat", 32'(err_cnt), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
